pipelined_adder: RTL and testbench

- Parametrised, pipelined multi-bit adder: sum = a + b + cin, split into STAGES equal chunks of ripple-carry full-adder cells.
- Each chunk sits behind its own register stage, and the carry is registered between stages.
- Streaming valid/ready interface on both sides, with full backpressure.
- Datapath arithmetic primitive for the counter, accumulator and ALU blocks that follow it.

---
 rtl/padd_pkg.sv | 23 ++
 rtl/padd_chunk.sv | 31 +++
 rtl/pipelined_adder.sv | 162 ++++++++++++++++
 tb/tb_pipelined_adder.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/padd_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// padd_pkg : shared defaults, chunk-width helper and stage control record
// Revision : 1.0
// ----------------------------------------------------------------------------
package padd_pkg;

  localparam int PADD_DEF_WIDTH  = 16;
  localparam int PADD_DEF_STAGES = 4;

  function automatic int chunk_w(input int width, input int stages);
    return width / stages;
  endfunction

  // The per-stage partial sum and pending operand fields change width from
  // stage to stage, so they live beside this record inside each stage scope.
  typedef struct packed {
    logic valid;
    logic carry;
  } padd_ctl_t;

endpackage
`default_nettype wire

// File: rtl/padd_chunk.sv
`default_nettype none
// ----------------------------------------------------------------------------
// padd_chunk : combinational CW-bit ripple-carry adder of one-bit full adders
// Revision   : 1.0
// ----------------------------------------------------------------------------
module padd_chunk #(
  parameter int CW = 4
) (
  input  logic [CW-1:0] a_i,
  input  logic [CW-1:0] b_i,
  input  logic          cin_i,
  output logic [CW-1:0] s_o,
  output logic          co_o,
  output logic          msb_cin_o
);

  logic [CW:0] w_c;

  assign w_c[0] = cin_i;

  for (genvar i = 0; i < CW; i++) begin : g_fa
    assign s_o[i]   = a_i[i] ^ b_i[i] ^ w_c[i];
    assign w_c[i+1] = (a_i[i] & b_i[i]) | (w_c[i] & (a_i[i] ^ b_i[i]));
  end

  // Carry into the top bit; XOR with carry out gives signed overflow.
  assign co_o      = w_c[CW];
  assign msb_cin_o = w_c[CW-1];

endmodule
`default_nettype wire

// File: rtl/pipelined_adder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pipelined_adder : STAGES-deep chunked adder with valid/ready and backpressure
// Optional macro  : PADD_OVF_EN adds the registered signed-overflow output ovf
// Revision        : 1.0
// ----------------------------------------------------------------------------
module pipelined_adder
  import padd_pkg::*;
#(
  parameter int WIDTH  = PADD_DEF_WIDTH,
  parameter int STAGES = PADD_DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef PADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = chunk_w(WIDTH, STAGES);

  if (WIDTH < 1 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_cfg
    $error("pipelined_adder: WIDTH must be >= 1 and a multiple of STAGES (1..WIDTH)");
  end

  logic             w_stall;
  logic             w_en;
  logic             w_accept;
  logic [WIDTH-1:0] w_a_in;
  logic [WIDTH-1:0] w_b_in;
  logic             w_cin_in;

  assign w_stall  = out_valid & ~out_ready;
  assign w_en     = ~w_stall;
  assign in_ready = ~w_stall & ~rst;
  assign w_accept = in_valid & in_ready;

  // Non-accepted operands enter as zero so no X ever reaches the outputs.
  assign w_a_in   = w_accept ? a : '0;
  assign w_b_in   = w_accept ? b : '0;
  assign w_cin_in = w_accept & cin;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int SW = (k + 1) * CW;
    localparam int PW = WIDTH - SW;

    padd_ctl_t     ctl_q;
    padd_ctl_t     ctl_d;
    logic [SW-1:0] sum_q;
    logic [SW-1:0] sum_d;
    logic [CW-1:0] w_a;
    logic [CW-1:0] w_b;
    logic          w_cin;
    logic [CW-1:0] w_s;
    logic          w_co;
    logic          w_msb_cin;

    padd_chunk #(
      .CW(CW)
    ) u_chunk (
      .a_i      (w_a),
      .b_i      (w_b),
      .cin_i    (w_cin),
      .s_o      (w_s),
      .co_o     (w_co),
      .msb_cin_o(w_msb_cin)
    );

    if (k == 0) begin : g_first
      assign w_a   = w_a_in[CW-1:0];
      assign w_b   = w_b_in[CW-1:0];
      assign w_cin = w_cin_in;
      assign ctl_d = '{valid: w_accept, carry: w_co};
      assign sum_d = w_s;
    end else begin : g_next
      assign w_a   = g_stage[k-1].g_pend.a_q[CW-1:0];
      assign w_b   = g_stage[k-1].g_pend.b_q[CW-1:0];
      assign w_cin = g_stage[k-1].ctl_q.carry;
      assign ctl_d = '{valid: g_stage[k-1].ctl_q.valid, carry: w_co};
      assign sum_d = {w_s, g_stage[k-1].sum_q};
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        ctl_q <= '0;
        sum_q <= '0;
      end else if (w_en) begin
        ctl_q <= ctl_d;
        sum_q <= sum_d;
      end
    end

    // Operand bits not yet consumed, stored right-aligned to the next chunk.
    if (PW > 0) begin : g_pend
      logic [PW-1:0] a_q;
      logic [PW-1:0] b_q;
      logic [PW-1:0] a_d;
      logic [PW-1:0] b_d;

      if (k == 0) begin : g_src_in
        assign a_d = w_a_in[WIDTH-1:CW];
        assign b_d = w_b_in[WIDTH-1:CW];
      end else begin : g_src_prev
        assign a_d = g_stage[k-1].g_pend.a_q[PW+CW-1:CW];
        assign b_d = g_stage[k-1].g_pend.b_q[PW+CW-1:CW];
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (w_en) begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end

`ifdef PADD_OVF_EN
    localparam bit MSB_USED = (k == STAGES - 1);
`else
    localparam bit MSB_USED = 1'b0;
`endif
    if (!MSB_USED) begin : g_sink
      logic unused_msb_cin;
      assign unused_msb_cin = w_msb_cin;
    end
  end

  assign out_valid = g_stage[STAGES-1].ctl_q.valid;
  assign sum       = g_stage[STAGES-1].sum_q;
  assign cout      = g_stage[STAGES-1].ctl_q.carry;

`ifdef PADD_OVF_EN
  logic ovf_q;
  logic ovf_d;

  assign ovf_d = g_stage[STAGES-1].w_msb_cin ^ g_stage[STAGES-1].w_co;

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (w_en) begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipelined_adder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_pipelined_adder : scoreboard bench for pipelined_adder (+ STAGES corners)
// Revision           : 1.0
// ----------------------------------------------------------------------------
module tb_pipelined_adder;

  localparam int W  = 16;
  localparam int ST = 4;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         o;
    int           cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         cout;
`ifdef PADD_OVF_EN
  logic         ovf;
`endif

  logic         c_valid = 1'b0;
  logic         c_out_ready = 1'b1;
  logic         c_in_ready  [3];
  logic         c_out_valid [3];
  logic [W-1:0] c_sum       [3];
  logic         c_cout      [3];
`ifdef PADD_OVF_EN
  logic         c_ovf       [3];
`endif

  int   checks  = 0;
  int   errors  = 0;
  int   cyc     = 0;
  logic lat_chk = 1'b1;
  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pipelined_adder #(.WIDTH(W), .STAGES(ST)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout)
`ifdef PADD_OVF_EN
    , .ovf(ovf)
`endif
  );

  pipelined_adder #(.WIDTH(W), .STAGES(1)) u_c1 (
    .clk(clk), .rst(rst), .in_valid(c_valid), .in_ready(c_in_ready[0]),
    .a(a), .b(b), .cin(cin), .out_valid(c_out_valid[0]), .out_ready(c_out_ready),
    .sum(c_sum[0]), .cout(c_cout[0])
`ifdef PADD_OVF_EN
    , .ovf(c_ovf[0])
`endif
  );

  pipelined_adder #(.WIDTH(W), .STAGES(2)) u_c2 (
    .clk(clk), .rst(rst), .in_valid(c_valid), .in_ready(c_in_ready[1]),
    .a(a), .b(b), .cin(cin), .out_valid(c_out_valid[1]), .out_ready(c_out_ready),
    .sum(c_sum[1]), .cout(c_cout[1])
`ifdef PADD_OVF_EN
    , .ovf(c_ovf[1])
`endif
  );

  pipelined_adder #(.WIDTH(W), .STAGES(16)) u_c16 (
    .clk(clk), .rst(rst), .in_valid(c_valid), .in_ready(c_in_ready[2]),
    .a(a), .b(b), .cin(cin), .out_valid(c_out_valid[2]), .out_ready(c_out_ready),
    .sum(c_sum[2]), .cout(c_cout[2])
`ifdef PADD_OVF_EN
    , .ovf(c_ovf[2])
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    logic [W:0] r;
    r         = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    model.s   = r[W-1:0];
    model.c   = r[W];
    model.o   = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
    model.cyc = 0;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc);
    exp_t e;
    bit   done;
    done     = 1'b0;
    in_valid = 1'b1;
    a        = ta;
    b        = tb;
    cin      = tc;
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge clk);
      if (in_ready) begin
        e     = model(ta, tb, tc);
        e.cyc = cyc + ST;
        sb.push_back(e);
        done  = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    check("accept_timeout", 32'(done), 32'd1);
  endtask

  task automatic drain();
    for (int n = 0; n < 60 && sb.size() != 0; n++) begin
      @(posedge clk);
      #1;
    end
    check("drain_empty", sb.size(), 32'd0);
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      check("out_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check("sum", 32'(sum), 32'(mon_e.s));
        check("cout", 32'(cout), 32'(mon_e.c));
`ifdef PADD_OVF_EN
        check("ovf", 32'(ovf), 32'(mon_e.o));
`endif
        if (lat_chk) check("latency", cyc, mon_e.cyc);
      end
    end
  end

  initial begin
    exp_t         f;
    int           lat [3];
    logic [W-1:0] cs  [3];
    logic         cc  [3];
    int           stg [3];
    stg = '{1, 2, 16};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Directed operands
    send(16'hFFFF, 16'h0001, 1'b0);
    send(16'h1234, 16'h4321, 1'b1);
    in_valid = 1'b0;
    drain();

    // Back-to-back random stream
    for (int i = 0; i < 100; i++)
      send(W'($urandom), W'($urandom), 1'($urandom));
    in_valid = 1'b0;
    drain();

    // Backpressure with four ops in flight
    lat_chk   = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      send(W'($urandom), W'($urandom), 1'($urandom));
    in_valid = 1'b0;
    f = sb[0];
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_sum", 32'(sum), 32'(f.s));
      check("stall_cout", 32'(cout), 32'(f.c));
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("release_out_valid", 32'(out_valid), 32'd1);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check("release_done", 32'(out_valid), 32'd0);
    check("release_sb_empty", sb.size(), 32'd0);
    @(posedge clk);
    #1;
    lat_chk = 1'b1;

    // Reset with three ops in flight
    for (int i = 0; i < 3; i++)
      send(W'($urandom), W'($urandom), 1'b1);
    in_valid = 1'b0;
    rst      = 1'b1;
    sb.delete();
    @(negedge clk);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_sum", 32'(sum), 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("midrst_no_stale", 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;
    end

    // STAGES corners: 1, 2, 16
    a       = 16'h8000;
    b       = 16'h8000;
    cin     = 1'b1;
    c_valid = 1'b1;
    for (int j = 0; j < 3; j++) begin
      lat[j] = 0;
      cs[j]  = '0;
      cc[j]  = 1'b0;
    end
    @(negedge clk);
    for (int j = 0; j < 3; j++) check("corner_in_ready", 32'(c_in_ready[j]), 32'd1);
    @(posedge clk);
    #1;
    c_valid = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      for (int j = 0; j < 3; j++) begin
        if (c_out_valid[j] && lat[j] == 0) begin
          lat[j] = n;
          cs[j]  = c_sum[j];
          cc[j]  = c_cout[j];
`ifdef PADD_OVF_EN
          check("corner_ovf", 32'(c_ovf[j]), 32'd1);
`endif
        end
      end
    end
    for (int j = 0; j < 3; j++) begin
      check("corner_latency", lat[j], stg[j]);
      check("corner_sum", 32'(cs[j]), 32'h0001);
      check("corner_cout", 32'(cc[j]), 32'd1);
    end
    @(posedge clk);
    #1;

`ifdef PADD_OVF_EN
    send(16'h7FFF, 16'h0001, 1'b0);
    send(16'hFFFF, 16'h0001, 1'b0);
    send(16'h8000, 16'h8000, 1'b0);
    in_valid = 1'b0;
    drain();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
